// File: rtl/mext_writeback_if.sv
// Bus bundle for the mext_writeback result-collection stage.
// Carries the issue handshake, per-unit completion/result lines and the
// memory write port. The controller side uses the master modport and the
// writeback stage uses the slave modport.
interface mext_writeback_if #(
  parameter int NUNITS = 4
);
  localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  logic                   issue_valid;
  logic [UW-1:0]          issue_unit;
  logic [31:0]            issue_addr;
  logic [NUNITS-1:0]      issue_ready;
  logic [NUNITS-1:0]      complete_in;
  logic [32*NUNITS-1:0]   result_in;
  logic                   write_mem;
  logic [31:0]            write_address;
  logic [31:0]            write_data;
  logic [2:0]             funct3;
  logic                   busy;
  logic                   orphan_err;

  modport master (
    output issue_valid, issue_unit, issue_addr, complete_in, result_in,
    input  issue_ready, write_mem, write_address, write_data, funct3,
           busy, orphan_err
  );

  modport slave (
    input  issue_valid, issue_unit, issue_addr, complete_in, result_in,
    output issue_ready, write_mem, write_address, write_data, funct3,
           busy, orphan_err
  );
endinterface

// File: rtl/mext_writeback.sv
// mext_writeback: collects results from the multiply-type units
// (0=mulhsu, 1=lui, 2=mul, 3=mulhu) and drains them to memory one word per
// cycle using round-robin arbitration.
// Each unit owns one slot that moves IDLE -> WAIT (issued) -> DONE
// (result captured) -> IDLE (written out).
// Optional performance counters are enabled by defining MEXT_WB_PERF_EN,
// which adds the wr_count and orphan_count outputs.
module mext_writeback #(
  parameter int         NUNITS      = 4,
  parameter logic [2:0] FUNCT3_WORD = 3'b010
) (
  input  logic                clk,
  input  logic                rst,
  mext_writeback_if.slave     bus
`ifdef MEXT_WB_PERF_EN
  ,
  output logic [15:0]         wr_count,
  output logic [7:0]          orphan_count
`endif
);

  localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_t;

  slot_state_t        state_q [NUNITS];
  slot_state_t        state_d [NUNITS];
  logic [31:0]        addr_q  [NUNITS];
  logic [31:0]        data_q  [NUNITS];

  logic [NUNITS-1:0]  pending;
  logic [NUNITS-1:0]  ready;
  logic [NUNITS-1:0]  issue_hit;
  logic [NUNITS-1:0]  capture;
  logic [NUNITS-1:0]  orphan_hit;

  logic [UW-1:0]      rr_ptr_q;
  logic [UW-1:0]      rr_ptr_d;
  logic [UW-1:0]      grant_idx;
  logic               grant_valid;
  int                 search_idx;

  logic               write_mem_q;
  logic [31:0]        write_address_q;
  logic [31:0]        write_data_q;
  logic [2:0]         funct3_q;
  logic               orphan_err_q;

  // Decode per-slot status and classify this cycle's issue/completion events
  always_comb begin
    pending    = '0;
    ready      = '0;
    issue_hit  = '0;
    capture    = '0;
    orphan_hit = '0;
    for (int k = 0; k < NUNITS; k++) begin
      pending[k]    = (state_q[k] != SLOT_IDLE);
      ready[k]      = (state_q[k] == SLOT_DONE);
      issue_hit[k]  = bus.issue_valid && (bus.issue_unit == UW'(k)) &&
                      (state_q[k] == SLOT_IDLE);
      capture[k]    = bus.complete_in[k] && (state_q[k] == SLOT_WAIT);
      orphan_hit[k] = bus.complete_in[k] && (state_q[k] != SLOT_WAIT);
    end
  end

  // Round-robin search for the first ready slot at or after rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = 0;
    for (int i = 0; i < NUNITS; i++) begin
      search_idx = (int'(rr_ptr_q) + i) % NUNITS;
      if (!grant_valid && ready[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = UW'(search_idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = UW'((int'(grant_idx) + 1) % NUNITS);
    end
  end

  // Slot next-state: issue opens a slot, completion fills it, grant frees it
  always_comb begin
    for (int k = 0; k < NUNITS; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        SLOT_IDLE: if (issue_hit[k]) state_d[k] = SLOT_WAIT;
        SLOT_WAIT: if (capture[k])   state_d[k] = SLOT_DONE;
        SLOT_DONE: if (grant_valid && (grant_idx == UW'(k))) state_d[k] = SLOT_IDLE;
        default:   state_d[k] = SLOT_IDLE;
      endcase
    end
  end

  // Slot state and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUNITS; k++) begin
        state_q[k] <= SLOT_IDLE;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int k = 0; k < NUNITS; k++) begin
        state_q[k] <= state_d[k];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Destination address and result storage; only meaningful while pending
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUNITS; k++) begin
      if (issue_hit[k]) begin
        addr_q[k] <= bus.issue_addr;
      end
      if (capture[k]) begin
        data_q[k] <= bus.result_in[32*k +: 32];
      end
    end
  end

  // Registered memory write port and sticky orphan-completion flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_mem_q     <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      funct3_q        <= '0;
      orphan_err_q    <= 1'b0;
    end else begin
      write_mem_q <= grant_valid;
      if (grant_valid) begin
        write_address_q <= addr_q[grant_idx];
        write_data_q    <= data_q[grant_idx];
        funct3_q        <= FUNCT3_WORD;
      end
      if (|orphan_hit) begin
        orphan_err_q <= 1'b1;
      end
    end
  end

  assign bus.issue_ready   = ~pending;
  assign bus.busy          = |pending;
  assign bus.write_mem     = write_mem_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.funct3        = funct3_q;
  assign bus.orphan_err    = orphan_err_q;

`ifdef MEXT_WB_PERF_EN
  logic [8:0] orphan_sum;

  // Orphan count sums all orphan events this cycle and saturates at 0xFF
  always_comb begin
    orphan_sum = {1'b0, orphan_count};
    for (int k = 0; k < NUNITS; k++) begin
      orphan_sum = orphan_sum + 9'(orphan_hit[k]);
    end
  end

  // Write counter wraps; orphan counter saturates
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_count     <= '0;
      orphan_count <= '0;
    end else begin
      wr_count     <= wr_count + 16'(write_mem_q);
      orphan_count <= (orphan_sum > 9'd255) ? 8'hFF : orphan_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_mext_writeback.sv
// Self-checking bench for mext_writeback. Expected writes are queued when a
// completion is driven and compared as write_mem pulses appear.
// Define MEXT_WB_PERF_EN to also exercise the performance counters.
module tb_mext_writeback;
  localparam int NUNITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mext_writeback_if #(.NUNITS(NUNITS)) bus ();

`ifdef MEXT_WB_PERF_EN
  logic [15:0] wr_count;
  logic [7:0]  orphan_count;
`endif

  mext_writeback #(
    .NUNITS      (NUNITS),
    .FUNCT3_WORD (3'b010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MEXT_WB_PERF_EN
    ,
    .wr_count     (wr_count),
    .orphan_count (orphan_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  unit;
    logic [31:0] addr;
    logic [31:0] result;
    logic [3:0]  exp_ready;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[4];
  int   checks = 0;
  int   passes = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, then return the inputs to idle
  task automatic apply_stimulus(input logic iv, input logic [1:0] unit,
                                input logic [31:0] addr, input logic [3:0] comp,
                                input logic [127:0] res);
    bus.issue_valid = iv;
    bus.issue_unit  = unit;
    bus.issue_addr  = addr;
    bus.complete_in = comp;
    bus.result_in   = res;
    tick();
    bus.issue_valid = 1'b0;
    bus.complete_in = '0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check_output("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Write monitor: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.write_mem === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got address 0x%08h data 0x%08h, expected no write",
                 bus.write_address, bus.write_data);
      end else begin
        mon_e = sb.pop_front();
        check_output("write_address", bus.write_address, mon_e.addr);
        check_output("write_data", bus.write_data, mon_e.data);
        check_output("funct3", 32'(bus.funct3), 32'd2);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [127:0] res;

    vecs[0] = '{2'd2, 32'h0000_0040, 32'h0000_00C8, 4'b1011, 32'h0000_0040, 32'h0000_00C8};
    vecs[1] = '{2'd0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1110, 32'h0000_0100, 32'hDEAD_BEEF};
    vecs[2] = '{2'd1, 32'h0000_0000, 32'h1234_5678, 4'b1101, 32'h0000_0000, 32'h1234_5678};
    vecs[3] = '{2'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0111, 32'hFFFF_FFFC, 32'hFFFF_FFFF};

    bus.issue_valid = 1'b0;
    bus.issue_unit  = '0;
    bus.issue_addr  = '0;
    bus.complete_in = '0;
    bus.result_in   = '0;

    // Reset hold then release
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_output("rst_write_mem", 32'(bus.write_mem), 32'd0);
    check_output("rst_write_address", bus.write_address, 32'd0);
    check_output("rst_write_data", bus.write_data, 32'd0);
    check_output("rst_funct3", 32'(bus.funct3), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_orphan_err", 32'(bus.orphan_err), 32'd0);
    check_output("rst_issue_ready", 32'(bus.issue_ready), 32'hF);

    // Single-unit transactions with latency and slot-free timing
    for (int v = 0; v < 4; v++) begin
      apply_stimulus(1'b1, vecs[v].unit, vecs[v].addr, 4'b0000, '0);
      check_output("vec_issue_ready", 32'(bus.issue_ready), 32'(vecs[v].exp_ready));
      check_output("vec_busy", 32'(bus.busy), 32'd1);
      res = '0;
      res[32*vecs[v].unit +: 32] = vecs[v].result;
      push_exp(vecs[v].exp_addr, vecs[v].exp_data);
      apply_stimulus(1'b0, 2'd0, 32'd0, 4'(1 << vecs[v].unit), res);
      check_output("vec_wm_c1", 32'(bus.write_mem), 32'd0);
      check_output("vec_ready_held", 32'(bus.issue_ready), 32'(vecs[v].exp_ready));
      tick();
      check_output("vec_wm_c2", 32'(bus.write_mem), 32'd1);
      check_output("vec_ready_freed", 32'(bus.issue_ready), 32'hF);
      tick();
      check_output("vec_wm_single", 32'(bus.write_mem), 32'd0);
      wait_drain(5);
    end

    // Four simultaneous completions drain back-to-back in rr order
    for (int u = 0; u < 4; u++) begin
      apply_stimulus(1'b1, 2'(u), 32'h10 + 32'(4 * u), 4'b0000, '0);
    end
    check_output("all_issue_ready", 32'(bus.issue_ready), 32'h0);
    res = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int u = 0; u < 4; u++) push_exp(32'h10 + 32'(4 * u), 32'hA0 + 32'(u));
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b1111, res);
    check_output("burst_wm_c1", 32'(bus.write_mem), 32'd0);
    for (int u = 0; u < 4; u++) begin
      tick();
      check_output("burst_wm", 32'(bus.write_mem), 32'd1);
    end
    tick();
    check_output("burst_wm_end", 32'(bus.write_mem), 32'd0);
    wait_drain(5);

    // Unit 1 again after pointer wrap
    apply_stimulus(1'b1, 2'd1, 32'h20, 4'b0000, '0);
    push_exp(32'h20, 32'hB1);
    res = '0;
    res[63:32] = 32'hB1;
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0010, res);
    wait_drain(10);

    // Orphan completion on an idle slot, then ignored re-issue
    check_output("orphan_pre", 32'(bus.orphan_err), 32'd0);
    res = '0;
    res[127:96] = 32'hEEEE_EEEE;
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b1000, res);
    check_output("orphan_set", 32'(bus.orphan_err), 32'd1);
    check_output("orphan_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    apply_stimulus(1'b1, 2'd0, 32'h50, 4'b0000, '0);
    apply_stimulus(1'b1, 2'd0, 32'h99, 4'b0000, '0);
    check_output("reissue_ready", 32'(bus.issue_ready), 32'hE);
    push_exp(32'h50, 32'h55);
    res = '0;
    res[31:0] = 32'h55;
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0001, res);
    wait_drain(10);
    check_output("orphan_sticky", 32'(bus.orphan_err), 32'd1);

    // Move rr_ptr to 3 before the reset test
    apply_stimulus(1'b1, 2'd2, 32'h60, 4'b0000, '0);
    push_exp(32'h60, 32'h66);
    res = '0;
    res[95:64] = 32'h66;
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0100, res);
    wait_drain(10);

    // Reset with units 0 and 1 in DONE discards their results
    apply_stimulus(1'b1, 2'd0, 32'h70, 4'b0000, '0);
    apply_stimulus(1'b1, 2'd1, 32'h74, 4'b0000, '0);
    res = {32'h0, 32'h0, 32'h71, 32'h70};
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0011, res);
    check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_output("post_reset_busy", 32'(bus.busy), 32'd0);
    check_output("post_reset_orphan", 32'(bus.orphan_err), 32'd0);
    check_output("post_reset_wm", 32'(bus.write_mem), 32'd0);
    check_output("post_reset_ready", 32'(bus.issue_ready), 32'hF);
    repeat (4) tick();

    // rr_ptr restarts at 0; duplicate completion on a DONE slot is ignored
    apply_stimulus(1'b1, 2'd3, 32'h83, 4'b0000, '0);
    apply_stimulus(1'b1, 2'd0, 32'h80, 4'b0000, '0);
    push_exp(32'h80, 32'hC0);
    push_exp(32'h83, 32'hC3);
    res = {32'hC3, 32'h0, 32'h0, 32'hC0};
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b1001, res);
    res = {32'h0000_0BAD, 32'h0, 32'h0, 32'h0};
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b1000, res);
    check_output("dup_orphan", 32'(bus.orphan_err), 32'd1);
    wait_drain(10);

`ifdef MEXT_WB_PERF_EN
    // Counters: third write, second orphan, then saturation
    apply_stimulus(1'b1, 2'd1, 32'h90, 4'b0000, '0);
    push_exp(32'h90, 32'h91);
    res = '0;
    res[63:32] = 32'h91;
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0010, res);
    wait_drain(10);
    repeat (2) tick();
    check_output("wr_count", 32'(wr_count), 32'd3);
    apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0100, '0);
    tick();
    check_output("orphan_count", 32'(orphan_count), 32'd2);
    for (int i = 0; i < 256; i++) apply_stimulus(1'b0, 2'd0, 32'd0, 4'b0100, '0);
    tick();
    check_output("orphan_count_sat", 32'(orphan_count), 32'hFF);
    check_output("wr_count_hold", 32'(wr_count), 32'd3);
`endif

    repeat (3) tick();
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mext_writeback.md
Name: mext_writeback

Overview:
Result-collection stage downstream of the multiply-type units (mul, mulhu, mulhsu, lui). Holds one destination address per unit when the controller issues work, and captures each unit's 32-bit result on its completion pulse. Drains finished results to the memory write port one word per cycle under round-robin arbitration. Frees the controller from waiting on each unit serially.

Parameters:
NUNITS, 4, number of result sources; index 0=mulhsu, 1=lui, 2=mul, 3=mulhu
FUNCT3_WORD, 3'b010, funct3 value driven with every write (word store)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
issue_valid  in  1  controller registers a destination for issue_unit this cycle
issue_unit  in  2  unit index being issued
issue_addr  in  32  memory address that receives the unit's result
issue_ready  out  NUNITS  per-unit: slot free, issue accepted
complete_in  in  NUNITS  per-unit single-cycle completion pulse
result_in  in  32*NUNITS  unit results; unit k at bits [32k+31:32k]
write_mem  out  1  memory write strobe, one cycle per word
write_address  out  32  memory write address
write_data  out  32  memory write data
funct3  out  3  store size to memory
busy  out  1  OR of all slot pending bits
orphan_err  out  1  sticky: completion seen on a slot with no pending issue

Behaviour:
- Per slot k: pending[k], ready[k], addr[k], data[k]. Slot states: IDLE (pending=0), WAIT (pending=1, ready=0), DONE (pending=1, ready=1).
- Reset (rst==0 at edge): all pending/ready=0, rr_ptr=0, write_mem=0, write_address=0, write_data=0, funct3=0, orphan_err=0. Reset mid-drain discards all buffered results.
- issue_ready[k] = ~pending[k], combinational from registered state.
- IDLE->WAIT: issue_valid && issue_ready[issue_unit]. Latch addr[issue_unit]=issue_addr. Issue to a pending slot is ignored: no state change, no error.
- WAIT->DONE: complete_in[k]. Latch data[k]=result_in slice k.
- complete_in[k] in IDLE: data discarded, orphan_err<=1 (cleared only by reset).
- complete_in[k] in DONE: ignored, orphan_err<=1.
- Drain arbiter:
  - Each cycle, grant the first ready slot at or after rr_ptr, searching upward modulo NUNITS.
  - On grant g at the edge: write_mem<=1, write_address<=addr[g], write_data<=data[g], funct3<=FUNCT3_WORD.
  - Same edge: slot g returns to IDLE and rr_ptr<=(g+1) mod NUNITS.
  - No grant: write_mem<=0; address/data/funct3 hold their last values.
- Latency: complete_in high in cycle C leads to ready in C+1, grant at end of C+1, write_mem high in C+2 (minimum 2 cycles).
- Throughput: one write per cycle. Four simultaneous completions yield four back-to-back write cycles in rr order.
- Slot freed at grant is issuable in the cycle write_mem is high.
- Simultaneous issue and completion on different slots are independent.
- busy = |pending, registered-state derived.

Optional Feature:
Macro MEXT_WB_PERF_EN.
- Defined: adds outputs wr_count[15:0] and orphan_count[7:0].
  - wr_count increments on each write_mem=1 cycle, wrapping 0xFFFF->0.
  - orphan_count increments on each orphan/duplicate completion, saturating at 0xFF.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset hold then release, no stimulus -> all outputs 0, issue_ready=4'b1111, busy=0.
- Issue unit 2 addr 0x40, complete_in[2] with result 0x0000_00C8 -> exactly one write_mem pulse 2 cycles later, write_address=0x40, write_data=0xC8, funct3=3'b010; issue_ready[2] low until the grant edge.
- Issue units 0..3 at addrs 0x10/0x14/0x18/0x1C, pulse all complete_in together (results 0xA0..0xA3), rr_ptr=0 -> four consecutive writes 0x10,0x14,0x18,0x1C with matching data; then issue and complete unit 1 again and check its write uses rr_ptr=0 after wrap.
- complete_in[3] with no pending issue -> no write, orphan_err=1, persists until reset; a second issue to pending unit 0 with addr 0x99 -> write still uses the original address.
- Units 0 and 1 in DONE, assert rst=0 for one edge -> no writes afterwards, busy=0, orphan_err=0, rr_ptr restarts at 0.
- MEXT_WB_PERF_EN defined: 3 writes plus 2 orphan completions -> wr_count=3, orphan_count=2; force 256 orphans -> orphan_count stays 0xFF.
